// File: rtl/adder_sched_pkg.sv
// Shared constants, FSM state type and round-robin helper for the adder scheduler.
package adder_sched_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;

    typedef enum logic [1:0] {IDLE, LO, HI, RSP} sched_state_t;

    // On contention the requester that was not served last wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] valid, input logic last);
        logic [1:0] g;
        g = valid;
        if (valid == 2'b11) begin
            g = last ? 2'b01 : 2'b10;
        end
        return g;
    endfunction

endpackage

// File: rtl/adder_sched_adder.sv
// The core's single 8-bit ripple-carry adder with carry-out and signed overflow.
module adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] y,
    output logic       co,
    output logic       v
);

    logic [8:0] c;

    always_comb begin
        c    = '0;
        y    = '0;
        c[0] = ci;
        for (int i = 0; i < 8; i++) begin
            y[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co = c[8];
    // Overflow when the carry into the sign bit differs from the carry out of it.
    assign v  = c[8] ^ c[7];

endmodule

// File: rtl/adder_sched.sv
// Round-robin scheduler sharing one 8-bit adder between two requesters;
// 16-bit operations run as a low pass then a carry-chained high pass.
module adder_sched
    import adder_sched_pkg::*;
#(
    parameter bit RR_INIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req1_a,
    input  logic [15:0] req0_b,
    input  logic [15:0] req1_b,
    input  logic [1:0]  req0_op,
    input  logic [1:0]  req1_op,
    input  logic        req0_wide,
    input  logic        req1_wide,
    input  logic        req0_cin,
    input  logic        req1_cin,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [15:0] rsp_y,
    output logic        rsp_c,
    output logic        rsp_v,
    output logic        rsp_z
);

    sched_state_t state_q;
    logic         last_q;
    logic         id_q;
    logic [15:0]  a_q;
    logic [15:0]  b_q;
    logic [1:0]   op_q;
    logic         wide_q;
    logic         cin_q;
    logic [7:0]   res_lo_q;
    logic         carry_q;
    logic         rsp_valid_q;
    logic         rsp_id_q;
    logic [15:0]  rsp_y_q;
    logic         rsp_c_q;
    logic         rsp_v_q;
    logic         rsp_z_q;

    logic [1:0]   grant;
    logic [7:0]   b_byte;
    logic [7:0]   add_a;
    logic [7:0]   add_b;
    logic         add_ci;
    logic [7:0]   add_y;
    logic         add_co;
    logic         add_v;

    assign grant     = rr_pick(req_valid, last_q);
    assign req_ready = (state_q == IDLE) ? grant : 2'b00;

    // Operand byte follows the pass; the HI pass chains the carry from LO.
    always_comb begin
        add_a  = (state_q == HI) ? a_q[15:8] : a_q[7:0];
        b_byte = (state_q == HI) ? b_q[15:8] : b_q[7:0];
        add_b  = (op_q == OP_SUB) ? ~b_byte : b_byte;
        if (state_q == HI) begin
            add_ci = carry_q;
        end else begin
            case (op_q)
                OP_SUB:  add_ci = 1'b1;
                OP_ADC:  add_ci = cin_q;
                default: add_ci = 1'b0;
            endcase
        end
    end

    adder u_adder (
        .a  (add_a),
        .b  (add_b),
        .ci (add_ci),
        .y  (add_y),
        .co (add_co),
        .v  (add_v)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= RR_INIT;
            id_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_ADD;
            wide_q      <= 1'b0;
            cin_q       <= 1'b0;
            res_lo_q    <= '0;
            carry_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_y_q     <= '0;
            rsp_c_q     <= 1'b0;
            rsp_v_q     <= 1'b0;
            rsp_z_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant != 2'b00) begin
                        id_q    <= grant[1];
                        a_q     <= grant[1] ? req1_a    : req0_a;
                        b_q     <= grant[1] ? req1_b    : req0_b;
                        op_q    <= grant[1] ? req1_op   : req0_op;
                        wide_q  <= grant[1] ? req1_wide : req0_wide;
                        cin_q   <= grant[1] ? req1_cin  : req0_cin;
                        state_q <= LO;
                    end
                end
                LO: begin
                    res_lo_q <= add_y;
                    carry_q  <= add_co;
                    if (wide_q) begin
                        state_q <= HI;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        rsp_y_q     <= {8'h00, add_y};
                        rsp_c_q     <= add_co;
                        rsp_v_q     <= add_v;
                        rsp_z_q     <= (add_y == 8'h00);
                        state_q     <= RSP;
                    end
                end
                HI: begin
                    rsp_valid_q <= 1'b1;
                    rsp_id_q    <= id_q;
                    rsp_y_q     <= {add_y, res_lo_q};
                    rsp_c_q     <= add_co;
                    rsp_v_q     <= add_v;
                    rsp_z_q     <= ({add_y, res_lo_q} == 16'h0000);
                    state_q     <= RSP;
                end
                RSP: begin
                    rsp_valid_q <= 1'b0;
                    last_q      <= rsp_id_q;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_v     = rsp_v_q;
    assign rsp_z     = rsp_z_q;

endmodule

// File: tb/tb_adder_sched.sv
// Bench for adder_sched: directed vector table, arbitration/reset sequences and
// randomized operations against an arithmetic reference model.
module tb_adder_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req0_a, req1_a, req0_b, req1_b;
    logic [1:0]  req0_op, req1_op;
    logic        req0_wide, req1_wide, req0_cin, req1_cin;
    logic        rsp_valid, rsp_id, rsp_c, rsp_v, rsp_z;
    logic [15:0] rsp_y;

    int checks = 0;
    int errors = 0;

    adder_sched #(.RR_INIT(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_a    (req0_a),
        .req1_a    (req1_a),
        .req0_b    (req0_b),
        .req1_b    (req1_b),
        .req0_op   (req0_op),
        .req1_op   (req1_op),
        .req0_wide (req0_wide),
        .req1_wide (req1_wide),
        .req0_cin  (req0_cin),
        .req1_cin  (req1_cin),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .rsp_c     (rsp_c),
        .rsp_v     (rsp_v),
        .rsp_z     (rsp_z)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        logic        wide;
        logic        cin;
        logic [15:0] y;
        logic        c;
        logic        v;
        logic        z;
    } vec_t;

    typedef struct packed {
        logic [15:0] y;
        logic        c;
        logic        v;
        logic        z;
    } res_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic over the active width.
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic [1:0] op, input logic wide, input logic cin);
        longint m, aa, bb, sa, sb, u, s, ci;
        res_t r;
        m  = wide ? 65536 : 256;
        aa = longint'(a) % m;
        bb = longint'(b) % m;
        sa = (aa >= m / 2) ? aa - m : aa;
        sb = (bb >= m / 2) ? bb - m : bb;
        if (op == 2'b01) begin
            u   = aa - bb;
            s   = sa - sb;
            r.c = (aa >= bb);
        end else begin
            ci  = (op == 2'b10) ? longint'(cin) : 0;
            u   = aa + bb + ci;
            s   = sa + sb + ci;
            r.c = (u >= m);
        end
        r.y = 16'(((u % m) + m) % m);
        r.v = (s >= m / 2) || (s < -(m / 2));
        r.z = (r.y == 16'h0000);
        return r;
    endfunction

    task automatic drive(input logic id, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] op, input logic wide, input logic cin);
        if (id) begin
            req1_a = a; req1_b = b; req1_op = op; req1_wide = wide; req1_cin = cin;
        end else begin
            req0_a = a; req0_b = b; req0_op = op; req0_wide = wide; req0_cin = cin;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, req_ready, 2'b00);
        check({tag, "_valid"}, rsp_valid, 1'b0);
        check({tag, "_id"}, rsp_id, 1'b0);
        check({tag, "_y"}, rsp_y, 16'h0000);
        check({tag, "_cvz"}, {rsp_c, rsp_v, rsp_z}, 3'b000);
    endtask

    // Issue one operation alone and check latency, strobe width and result.
    task automatic run_op(input logic id, input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] op, input logic wide, input logic cin,
                          input logic [15:0] ey, input logic ec, input logic ev,
                          input logic ez, input string tag);
        int n;
        logic seen;
        @(negedge clk);
        drive(id, a, b, op, wide, cin);
        req_valid[id] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[id] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_accept"}, req_ready[id], 1'b1);
        if (!req_ready[id]) begin
            req_valid[id] = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid[id] = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 10) begin
            @(negedge clk);
            n++;
            seen = rsp_valid;
        end
        check({tag, "_latency"}, n, wide ? 3 : 2);
        check({tag, "_id"}, rsp_id, id);
        check({tag, "_y"}, rsp_y, ey);
        check({tag, "_cvz"}, {rsp_c, rsp_v, rsp_z}, {ec, ev, ez});
        @(negedge clk);
        check({tag, "_strobe_end"}, rsp_valid, 1'b0);
        check({tag, "_y_held"}, rsp_y, ey);
    endtask

    // Let a still-pending requester 1 be granted and complete.
    task automatic finish_req1(input string tag);
        int n;
        n = 0;
        #1;
        while (!req_ready[1] && n < 12) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_req1_granted"}, req_ready[1], 1'b1);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r;
        logic id, wide, cin;
        logic [15:0] a, b;
        logic [1:0] op;

        vecs[0] = '{1'b0, 16'h0070, 16'h0010, 2'b00, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 16'h0100, 16'h0001, 2'b01, 1'b1, 1'b0, 16'h00FF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 16'hFFFF, 16'h0000, 2'b10, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 16'h1234, 16'h0034, 2'b01, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 16'hAB80, 16'h0080, 2'b11, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 16'h7FFF, 16'h0001, 2'b00, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 16'h0001, 16'h0001, 2'b00, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 16'h007F, 16'h0000, 2'b10, 1'b0, 1'b1, 16'h0080, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 16'h0000, 16'h0001, 2'b01, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 16'h00FF, 16'h0001, 2'b00, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        req_valid = 2'b00;
        drive(1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b0);
        drive(1'b1, 16'h0, 16'h0, 2'b00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Arbitration straight after reset: req0 first, req1 held through LO/HI.
        @(negedge clk);
        drive(1'b0, 16'h1234, 16'h1111, 2'b00, 1'b1, 1'b0);
        drive(1'b1, 16'h0050, 16'h0030, 2'b01, 1'b0, 1'b0);
        req_valid = 2'b11;
        #1;
        check("arb_first_grant", req_ready, 2'b01);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("arb_hold_ready", req_ready, 2'b00);
        end
        check("arb_rsp0_valid", rsp_valid, 1'b1);
        check("arb_rsp0_id", rsp_id, 1'b0);
        check("arb_rsp0_y", rsp_y, 16'h2345);
        @(negedge clk);
        #1;
        check("arb_second_grant", req_ready, 2'b10);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        repeat (2) @(negedge clk);
        check("arb_rsp1_valid", rsp_valid, 1'b1);
        check("arb_rsp1_id", rsp_id, 1'b1);
        check("arb_rsp1_y", rsp_y, 16'h0020);
        check("arb_rsp1_cvz", {rsp_c, rsp_v, rsp_z}, 3'b100);
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        check("arb_third_grant", req_ready, 2'b01);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        finish_req1("arb_pair2");

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].wide, vecs[i].cin,
                   vecs[i].y, vecs[i].c, vecs[i].v, vecs[i].z, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            id   = 1'($urandom_range(0, 1));
            a    = 16'($urandom);
            b    = 16'($urandom);
            op   = 2'($urandom_range(0, 3));
            wide = 1'($urandom_range(0, 1));
            cin  = 1'($urandom_range(0, 1));
            r    = model(a, b, op, wide, cin);
            run_op(id, a, b, op, wide, cin, r.y, r.c, r.v, r.z, $sformatf("rand%0d", i));
        end

        // Leave req1 as last served, then reset during the HI pass of a wide op.
        run_op(1'b1, 16'h0003, 16'h0004, 2'b00, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0, "pre_rst");
        @(negedge clk);
        drive(1'b0, 16'h00FF, 16'h0001, 2'b00, 1'b1, 1'b0);
        req_valid = 2'b01;
        @(posedge clk);
        #1 req_valid = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rst_no_rsp", rsp_valid, 1'b0);
        end
        rst_n = 1'b1;

        // Pointer is back to its reset value: a simultaneous pair favours req0.
        @(negedge clk);
        check("post_rst_no_rsp", rsp_valid, 1'b0);
        drive(1'b0, 16'h0001, 16'h0001, 2'b00, 1'b0, 1'b0);
        drive(1'b1, 16'h0009, 16'h0001, 2'b00, 1'b0, 1'b0);
        req_valid = 2'b11;
        #1;
        check("post_rst_grant", req_ready, 2'b01);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_valid", rsp_valid, 1'b1);
        check("post_rst_id", rsp_id, 1'b0);
        check("post_rst_y", rsp_y, 16'h0002);
        @(negedge clk);
        finish_req1("post_rst");
        check("post_rst_req1_y", rsp_y, 16'h000A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
